// File: rtl/joycon_pkg.sv
// Shared types and constants for the Joy-Con to SNES controller bridge.
`timescale 1ns/1ps

package joycon_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLatch,
    StShift,
    StDone
  } pad_state_e;

  localparam int unsigned SNES_FRAME_BITS = 16;
  localparam int unsigned NUM_KEYS        = 12;

  localparam int unsigned KEY_B      = 0;
  localparam int unsigned KEY_Y      = 1;
  localparam int unsigned KEY_SELECT = 2;
  localparam int unsigned KEY_START  = 3;
  localparam int unsigned KEY_UP     = 4;
  localparam int unsigned KEY_DOWN   = 5;
  localparam int unsigned KEY_LEFT   = 6;
  localparam int unsigned KEY_RIGHT  = 7;
  localparam int unsigned KEY_A      = 8;
  localparam int unsigned KEY_X      = 9;
  localparam int unsigned KEY_L      = 10;
  localparam int unsigned KEY_R      = 11;

  // Console sees active-low buttons; the four trailing ID bits always read released.
  function automatic logic [SNES_FRAME_BITS-1:0] frame_word(input logic [NUM_KEYS-1:0] keys,
                                                            input logic connected);
    frame_word = {4'b1111, connected ? ~keys : {NUM_KEYS{1'b1}}};
  endfunction

endpackage

// File: rtl/joycon_sync_edge.sv
// Two-flop synchronizer for one console input followed by a rise/fall edge detector.
`timescale 1ns/1ps

module joycon_sync_edge (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q, sync_q, prev_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rise_o = sync_q & ~prev_q;
  assign fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/joycon_snes_pad.sv
// Presents a Joy-Con button vector as an SNES serial pad to an asynchronous console.
// Optional turbo masking is enabled by defining JOYCON_SNES_TURBO_EN.
`timescale 1ns/1ps

module joycon_snes_pad
  import joycon_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 50_000_000,
  parameter int unsigned TIMEOUT_US  = 1000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] keys_in,
`ifdef JOYCON_SNES_TURBO_EN
  input  logic [NUM_KEYS-1:0] turbo_mask,
`endif
  input  logic                pad_connected,
  input  logic                pad_latch,
  input  logic                pad_clk,
  output logic                pad_data,
  output logic                frame_done
);

  localparam int unsigned TimeoutCycles = TIMEOUT_US * (CLK_FREQ_HZ / 1_000_000);
  localparam int unsigned TmoW          = $clog2(TimeoutCycles + 1);
  localparam int unsigned CntW          = $clog2(SNES_FRAME_BITS + 1);

  logic latch_rise, latch_fall;
  logic clk_rise, clk_fall;

  joycon_sync_edge u_latch_sync (
    .clk_i  (clk),
    .rst_i  (rst),
    .async_i(pad_latch),
    .rise_o (latch_rise),
    .fall_o (latch_fall)
  );

  joycon_sync_edge u_clk_sync (
    .clk_i  (clk),
    .rst_i  (rst),
    .async_i(pad_clk),
    .rise_o (clk_rise),
    .fall_o (clk_fall)
  );

  logic [NUM_KEYS-1:0]        keys_eff;
  logic [SNES_FRAME_BITS-1:0] load_word;

`ifdef JOYCON_SNES_TURBO_EN
  logic turbo_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      turbo_q <= 1'b0;
    end else if (frame_done) begin
      turbo_q <= ~turbo_q;
    end
  end

  // On the off phase, turbo-enabled keys read as released.
  always_comb begin
    keys_eff = keys_in & ~(turbo_q ? turbo_mask : {NUM_KEYS{1'b0}});
  end
`else
  always_comb begin
    keys_eff = keys_in;
  end
`endif

  always_comb begin
    load_word = frame_word(keys_eff, pad_connected);
  end

  pad_state_e                 state_q;
  logic [SNES_FRAME_BITS-1:0] shift_q;
  logic [CntW-1:0]            cnt_q;
  logic [TmoW-1:0]            tmo_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      shift_q    <= {SNES_FRAME_BITS{1'b1}};
      cnt_q      <= '0;
      tmo_q      <= '0;
      pad_data   <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      // A new latch wins over everything, including a coincident clock edge.
      if (latch_rise) begin
        state_q  <= StLatch;
        shift_q  <= load_word;
        cnt_q    <= '0;
        tmo_q    <= '0;
        pad_data <= load_word[0];
      end else begin
        unique case (state_q)
          StIdle: begin
            pad_data <= 1'b1;
          end
          StLatch: begin
            if (latch_fall) begin
              state_q  <= StShift;
              cnt_q    <= '0;
              tmo_q    <= '0;
              pad_data <= shift_q[0];
            end else begin
              shift_q  <= load_word;
              pad_data <= load_word[0];
            end
          end
          StShift: begin
            if (clk_rise) begin
              shift_q <= {1'b0, shift_q[SNES_FRAME_BITS-1:1]};
              cnt_q   <= cnt_q + 1'b1;
              tmo_q   <= '0;
              if (cnt_q == CntW'(SNES_FRAME_BITS - 1)) begin
                state_q    <= StDone;
                frame_done <= 1'b1;
                pad_data   <= 1'b0;
              end else begin
                pad_data <= shift_q[1];
              end
            end else if (clk_fall) begin
              tmo_q <= '0;
            end else if (tmo_q == TmoW'(TimeoutCycles - 1)) begin
              state_q  <= StIdle;
              tmo_q    <= '0;
              pad_data <= 1'b1;
            end else begin
              tmo_q <= tmo_q + 1'b1;
            end
          end
          StDone: begin
            pad_data <= 1'b0;
          end
          default: begin
            state_q  <= StIdle;
            pad_data <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_joycon_snes_pad.sv
// Directed bench for joycon_snes_pad: frame contents, abort, timeout and reset behaviour.
`timescale 1ns/1ps

module tb_joycon_snes_pad;
  import joycon_pkg::*;

  localparam int unsigned ClkHz = 10_000_000;
  localparam int unsigned TmoUs = 1000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] keys_in = 12'h000;
  logic        pad_connected = 1'b1;
  logic        pad_latch = 1'b0;
  logic        pad_clk = 1'b1;
  logic        pad_data;
  logic        frame_done;
`ifdef JOYCON_SNES_TURBO_EN
  logic [11:0] turbo_mask = 12'h000;
`endif

  int vectors = 0;
  int fails   = 0;
  int fd_cnt  = 0;

  joycon_snes_pad #(
    .CLK_FREQ_HZ(ClkHz),
    .TIMEOUT_US (TmoUs)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .keys_in      (keys_in),
`ifdef JOYCON_SNES_TURBO_EN
    .turbo_mask   (turbo_mask),
`endif
    .pad_connected(pad_connected),
    .pad_latch    (pad_latch),
    .pad_clk      (pad_clk),
    .pad_data     (pad_data),
    .frame_done   (frame_done)
  );

  always #50 clk = ~clk;

  always @(posedge clk) begin
    if (frame_done) fd_cnt <= fd_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_latch();
    pad_latch = 1'b1;
    #12000;
    pad_latch = 1'b0;
    #3000;
  endtask

  // Bit i is sampled at the end of the low phase that precedes rising edge i.
  task automatic do_clocks(input int n, output logic [15:0] bits);
    bits = 16'hFFFF;
    for (int i = 0; i < n; i++) begin
      pad_clk = 1'b0;
      #3000;
      if (i < 16) bits[i] = pad_data;
      pad_clk = 1'b1;
      #3000;
    end
  endtask

  initial begin
    logic [15:0] bits;
    int          fd0;

    #1000;
    rst = 1'b0;
    #1000;
    check("reset_pad_data", 32'(pad_data), 32'h1);
    check("reset_frame_done", 32'(frame_done), 32'h0);
    check("reset_state", 32'(dut.state_q), 32'(StIdle));

    // B pressed only
    keys_in = 12'h001;
    fd0 = fd_cnt;
    do_latch();
    do_clocks(16, bits);
    #1000;
    check("b_only_bits", 32'(bits), 32'hFFFE);
    check("b_only_done_pulse", 32'(fd_cnt - fd0), 32'h1);
    check("b_only_tail", 32'(pad_data), 32'h0);

    // Mixed pattern; extra clocks in DONE must be ignored
    keys_in = 12'hA5A;
    fd0 = fd_cnt;
    do_latch();
    do_clocks(16, bits);
    #1000;
    check("a5a_bits", 32'(bits), 32'hF5A5);
    check("a5a_tail", 32'(pad_data), 32'h0);
    do_clocks(3, bits);
    #1000;
    check("done_ignores_clk", 32'(pad_data), 32'h0);
    check("a5a_done_pulse", 32'(fd_cnt - fd0), 32'h1);
    check("done_state", 32'(dut.state_q), 32'(StDone));

    // Disconnected pad reads all released
    keys_in = 12'hFFF;
    pad_connected = 1'b0;
    do_latch();
    do_clocks(16, bits);
    check("disconnected_bits", 32'(bits), 32'hFFFF);
    pad_connected = 1'b1;

    // Abort after 5 clocks, then a full frame
    keys_in = 12'h003;
    fd0 = fd_cnt;
    do_latch();
    do_clocks(5, bits);
    check("abort_no_done", 32'(fd_cnt - fd0), 32'h0);
    do_latch();
    do_clocks(16, bits);
    #1000;
    check("restart_bits", 32'(bits), 32'hFFFC);
    check("restart_done_pulse", 32'(fd_cnt - fd0), 32'h1);

    // Timeout: still shifting at 0.9 ms, idle by 1.1 ms
    keys_in = 12'h010;
    fd0 = fd_cnt;
    do_latch();
    do_clocks(3, bits);
    check("partial_bits", 32'(bits[2:0]), 32'h7);
    #900000;
    check("pre_timeout_state", 32'(dut.state_q), 32'(StShift));
    #200000;
    check("timeout_state", 32'(dut.state_q), 32'(StIdle));
    check("timeout_pad_data", 32'(pad_data), 32'h1);
    check("timeout_no_done", 32'(fd_cnt - fd0), 32'h0);

    // Reset mid-frame aborts without a pulse, then the pad recovers
    fd0 = fd_cnt;
    do_latch();
    do_clocks(5, bits);
    rst = 1'b1;
    #300;
    rst = 1'b0;
    #1000;
    check("rst_abort_state", 32'(dut.state_q), 32'(StIdle));
    check("rst_abort_pad_data", 32'(pad_data), 32'h1);
    check("rst_abort_no_done", 32'(fd_cnt - fd0), 32'h0);
    keys_in = 12'h800;
    do_latch();
    do_clocks(16, bits);
    check("post_rst_bits", 32'(bits), 32'hF7FF);

`ifdef JOYCON_SNES_TURBO_EN
    rst = 1'b1;
    #300;
    rst = 1'b0;
    #1000;
    turbo_mask = 12'h100;
    keys_in = 12'h100;
    do_latch();
    do_clocks(16, bits);
    check("turbo_frame1_bit8", 32'(bits[8]), 32'h0);
    check("turbo_frame1_bits", 32'(bits), 32'hFEFF);
    do_latch();
    do_clocks(16, bits);
    check("turbo_frame2_bit8", 32'(bits[8]), 32'h1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
